// File: rtl/pwm_fade_controller.sv
// Duty-cycle sequencer for pwm_peripheral: fixed-step ramps on a prescaled tick, direct writes win.
// Optional done pulse / sticky irq enabled by defining PWM_FADE_DONE_IRQ_EN.
module pwm_fade_controller #(
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dir_wr,
  input  logic [DUTY_W-1:0]  dir_duty,
  input  logic               start,
  input  logic               abort,
  input  logic [DUTY_W-1:0]  tgt_duty,
  input  logic [DUTY_W-1:0]  step,
  input  logic [PRESC_W-1:0] presc,
`ifdef PWM_FADE_DONE_IRQ_EN
  input  logic               irq_clr,
  output logic               done,
  output logic               irq,
`endif
  output logic [DUTY_W-1:0]  duty_out,
  output logic               busy
);

  typedef enum logic {StIdle, StRamp} state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUTY_W-1:0]  tgt_q, tgt_d;
  logic [DUTY_W-1:0]  step_q, step_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic               done_d;

  logic [DUTY_W-1:0]  step_eff;
  logic [DUTY_W:0]    diff;
  logic               up;
  logic               tick;

  always_comb begin
    step_eff = (step_q == '0) ? DUTY_W'(1) : step_q;
    up       = tgt_q > duty_q;
    // One extra bit so the distance compare never wraps.
    diff     = up ? ({1'b0, tgt_q} - {1'b0, duty_q}) : ({1'b0, duty_q} - {1'b0, tgt_q});
    tick     = (cnt_q == presc_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    duty_d  = duty_q;
    done_d  = 1'b0;

    if (dir_wr) begin
      duty_d  = dir_duty;
      state_d = StIdle;
      cnt_d   = '0;
    end else if (abort && state_q == StRamp) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (start) begin
      tgt_d   = tgt_duty;
      step_d  = step;
      presc_d = presc;
      cnt_d   = '0;
      if (state_q == StIdle && tgt_duty == duty_q) begin
        done_d = 1'b1;
      end else begin
        state_d = StRamp;
      end
    end else if (state_q == StRamp) begin
      if (tick) begin
        cnt_d = '0;
        if (diff <= {1'b0, step_eff}) begin
          duty_d  = tgt_q;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          duty_d = up ? (duty_q + step_eff) : (duty_q - step_eff);
        end
      end else begin
        cnt_d = cnt_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      presc_q <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      duty_q  <= duty_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = (state_q == StRamp);

`ifdef PWM_FADE_DONE_IRQ_EN
  logic done_q, irq_q;

  // A completion in the same cycle as irq_clr keeps irq set.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      if (done_d) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign done = done_q;
  assign irq  = irq_q;
`else
  logic unused_done;
  assign unused_done = done_d;
`endif

endmodule
